ads869x_reg_responder: RTL and testbench

ADS869X_REG_RESPONDER -- requirements
Module: ads869x_reg_responder

---
 rtl/ads869x_pkg.sv | 79 +++++++
 rtl/spi_edge_sync.sv | 52 +++++
 rtl/ads869x_reg_responder.sv | 166 ++++++++++++++++
 tb/tb_ads869x_reg_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ads869x_pkg.sv
// Register map, command codes and field encodings of the ADS869x SPI register
// interface, shared by the responder and the ADC controller side.
package ads869x_pkg;

  localparam int FRAME_BITS = 32;
  localparam int NUM_REGS   = 9;

  typedef enum logic [6:0] {
    CMD_NOP         = 7'b0000000,
    CMD_CLEAR_HWORD = 7'b1100000,
    CMD_READ_HWORD  = 7'b1100100,
    CMD_READ        = 7'b0100100,
    CMD_WRITE       = 7'b1101000,
    CMD_WRITE_MS    = 7'b1101001,
    CMD_WRITE_LS    = 7'b1101010,
    CMD_SET_HWORD   = 7'b1101100
  } cmd_e;

  localparam logic [8:0] ADDR_DEVICE_ID     = 9'h000;
  localparam logic [8:0] ADDR_RST_PWRCTL    = 9'h004;
  localparam logic [8:0] ADDR_SDI_CTL       = 9'h008;
  localparam logic [8:0] ADDR_SDO_CTL       = 9'h00C;
  localparam logic [8:0] ADDR_DATAOUT_CTL   = 9'h010;
  localparam logic [8:0] ADDR_RANGE_SEL     = 9'h014;
  localparam logic [8:0] ADDR_ALARM         = 9'h020;
  localparam logic [8:0] ADDR_ALARM_H_TH_LS = 9'h024;
  localparam logic [8:0] ADDR_ALARM_H_TH_MS = 9'h026;
  localparam logic [8:0] ADDR_ALARM_L_TH_LS = 9'h028;
  localparam logic [8:0] ADDR_ALARM_L_TH_MS = 9'h02A;

  localparam logic [3:0] IDX_DATAOUT_CTL = 4'd3;
  localparam logic [3:0] IDX_RANGE_SEL   = 4'd4;

  typedef enum logic [3:0] {
    RANGE_BIP_3P0   = 4'b0000,
    RANGE_BIP_2P5   = 4'b0001,
    RANGE_BIP_1P5   = 4'b0010,
    RANGE_BIP_1P25  = 4'b0011,
    RANGE_BIP_0P625 = 4'b0100,
    RANGE_UNI_3P0   = 4'b1000,
    RANGE_UNI_2P5   = 4'b1001,
    RANGE_UNI_1P5   = 4'b1010,
    RANGE_UNI_1P25  = 4'b1011
  } range_e;

  typedef enum logic [2:0] {
    PATTERN_CONV_DATA = 3'b000,
    PATTERN_ZEROS     = 3'b100,
    PATTERN_ONES      = 3'b101,
    PATTERN_ALT_01    = 3'b110,
    PATTERN_0011      = 3'b111
  } pattern_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } reg_sel_t;

  // Maps a halfword address onto the backing register file; hit is set only for writable halfwords.
  function automatic reg_sel_t reg_select(input logic [8:0] addr);
    reg_sel_t sel;
    sel.hit = 1'b1;
    sel.idx = 4'd0;
    case (addr)
      ADDR_RST_PWRCTL:    sel.idx = 4'd0;
      ADDR_SDI_CTL:       sel.idx = 4'd1;
      ADDR_SDO_CTL:       sel.idx = 4'd2;
      ADDR_DATAOUT_CTL:   sel.idx = IDX_DATAOUT_CTL;
      ADDR_RANGE_SEL:     sel.idx = IDX_RANGE_SEL;
      ADDR_ALARM_H_TH_LS: sel.idx = 4'd5;
      ADDR_ALARM_H_TH_MS: sel.idx = 4'd6;
      ADDR_ALARM_L_TH_LS: sel.idx = 4'd7;
      ADDR_ALARM_L_TH_MS: sel.idx = 4'd8;
      default:            sel.hit = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the three SPI pins into the clk domain and flags edges of cs_n and sclk.
module spi_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_sdi,
  output logic sdi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [1:0] cs_sync;
  logic [1:0] sclk_sync;
  logic [1:0] sdi_sync;
  logic       cs_prev;
  logic       sclk_prev;
  logic [1:0] settle;
  logic       armed;

  // cs edges stay masked until the synchronizer has refilled after reset and seen cs_n high,
  // so a frame already running at reset release never looks like a new start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      sdi_sync  <= 2'b00;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
      settle    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sclk_sync <= {sclk_sync[0], spi_sclk};
      sdi_sync  <= {sdi_sync[0], spi_sdi};
      cs_prev   <= cs_sync[1];
      sclk_prev <= sclk_sync[1];
      settle    <= {settle[0], 1'b1};
      if (settle[1] && cs_sync[1])
        armed <= 1'b1;
    end
  end

  assign sdi       = sdi_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_fall   = armed & cs_prev & ~cs_sync[1];
  assign cs_rise   = armed & ~cs_prev & cs_sync[1];

endmodule

// File: rtl/ads869x_reg_responder.sv
// SPI-slave model of the ADS869x configuration registers: decodes 32-bit frames,
// updates the register file and serves halfword/byte reads on the following frame.
module ads869x_reg_responder
  import ads869x_pkg::*;
#(
  parameter logic [15:0] DEVICE_ID     = 16'h0000,
  parameter int          MIN_CLK_RATIO = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic [3:0] range_sel,
  output logic       int_ref_dis,
  output logic [2:0] dataout_pattern,
  output logic       cfg_update,
  output logic       frame_err
);

  // Each sclk phase must last long enough for the two-flop synchronizer to see it.
  if (MIN_CLK_RATIO < 4) begin : g_ratio_check
    $error("MIN_CLK_RATIO must be at least 4");
  end

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);

  logic        sdi;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        cs_fall;
  logic        cs_rise;

  logic [15:0] regs [NUM_REGS];
  logic [31:0] shift_in;
  logic [31:0] shift_out;
  logic [5:0]  bit_cnt;
  logic        in_frame;
  logic        exec_pend;
  logic        pend_valid;
  logic [15:0] pend_data;

  logic [6:0]  cmd;
  logic [8:0]  addr;
  logic [15:0] data;
  logic [8:0]  rd_addr;
  reg_sel_t    wr_sel;
  reg_sel_t    rd_sel;
  logic [15:0] cur;
  logic [15:0] rd_hword;
  logic [15:0] wr_val;
  logic        wr_cmd;
  logic        rd_cmd;
  logic [15:0] rd_val;
  logic        do_write;
  logic        next_pend_valid;
  logic [15:0] next_pend_data;

  spi_edge_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_sdi   (spi_sdi),
    .sdi       (sdi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  // Command decode; the read result bypasses pend_* so a frame starting in the execute cycle sees it.
  always_comb begin
    cmd     = shift_in[31:25];
    addr    = shift_in[24:16];
    data    = shift_in[15:0];
    rd_addr = (cmd == CMD_READ) ? {addr[8:1], 1'b0} : addr;
    wr_sel  = reg_select(addr);
    rd_sel  = reg_select(rd_addr);
    cur     = wr_sel.hit ? regs[wr_sel.idx] : 16'h0000;

    if (rd_addr == ADDR_DEVICE_ID)
      rd_hword = DEVICE_ID;
    else if (rd_addr == ADDR_ALARM)
      rd_hword = 16'h0000;
    else if (rd_sel.hit)
      rd_hword = regs[rd_sel.idx];
    else
      rd_hword = 16'h0000;

    wr_val = cur;
    wr_cmd = 1'b0;
    rd_cmd = 1'b0;
    rd_val = 16'h0000;
    case (cmd)
      CMD_WRITE:       begin wr_cmd = 1'b1; wr_val = data; end
      CMD_WRITE_MS:    begin wr_cmd = 1'b1; wr_val = {data[15:8], cur[7:0]}; end
      CMD_WRITE_LS:    begin wr_cmd = 1'b1; wr_val = {cur[15:8], data[7:0]}; end
      CMD_SET_HWORD:   begin wr_cmd = 1'b1; wr_val = cur | data; end
      CMD_CLEAR_HWORD: begin wr_cmd = 1'b1; wr_val = cur & ~data; end
      CMD_READ_HWORD:  begin rd_cmd = 1'b1; rd_val = rd_hword; end
      CMD_READ:        begin rd_cmd = 1'b1; rd_val = {addr[0] ? rd_hword[15:8] : rd_hword[7:0], 8'h00}; end
      default:         ;
    endcase

    do_write        = exec_pend & wr_cmd & wr_sel.hit;
    next_pend_valid = pend_valid | (exec_pend & rd_cmd);
    next_pend_data  = (exec_pend & rd_cmd) ? rd_val : pend_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= 16'h0000;
      shift_in   <= '0;
      shift_out  <= '0;
      bit_cnt    <= '0;
      in_frame   <= 1'b0;
      exec_pend  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      exec_pend  <= 1'b0;
      cfg_update <= do_write;
      frame_err  <= 1'b0;
      pend_valid <= next_pend_valid;
      pend_data  <= next_pend_data;
      if (do_write)
        regs[wr_sel.idx] <= wr_val;

      if (cs_fall) begin
        in_frame   <= 1'b1;
        bit_cnt    <= '0;
        shift_out  <= next_pend_valid ? {next_pend_data, 16'h0000} : 32'h0;
        pend_valid <= 1'b0;
        pend_data  <= '0;
      end else if (in_frame) begin
        if (cs_rise) begin
          in_frame <= 1'b0;
          if (bit_cnt == CNT_FULL)
            exec_pend <= 1'b1;
          else
            frame_err <= 1'b1;
        end else begin
          if (sclk_rise) begin
            shift_in <= {shift_in[30:0], sdi};
            if (bit_cnt != CNT_SAT)
              bit_cnt <= bit_cnt + 6'd1;
          end
          if (sclk_fall)
            shift_out <= {shift_out[30:0], 1'b0};
        end
      end
    end
  end

  assign spi_sdo         = in_frame & shift_out[31];
  assign range_sel       = regs[IDX_RANGE_SEL][3:0];
  assign int_ref_dis     = regs[IDX_RANGE_SEL][6];
  assign dataout_pattern = regs[IDX_DATAOUT_CTL][2:0];

endmodule

// File: tb/tb_ads869x_reg_responder.sv
// Drives SPI frames into ads869x_reg_responder and checks it against a register-map model.
module tb_ads869x_reg_responder;

  localparam logic [15:0] DEV_ID = 16'hA5C3;
  localparam logic [6:0] C_WRITE = 7'b1101000, C_WRITE_MS = 7'b1101001, C_WRITE_LS = 7'b1101010;
  localparam logic [6:0] C_SET = 7'b1101100, C_CLEAR = 7'b1100000;
  localparam logic [6:0] C_RDH = 7'b1100100, C_READ = 7'b0100100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_sdi = 1'b0;
  logic       spi_sdo;
  logic [3:0] range_sel;
  logic       int_ref_dis;
  logic [2:0] dataout_pattern;
  logic       cfg_update;
  logic       frame_err;

  int n_cmp = 0;
  int n_fail = 0;
  int cfg_cnt = 0;
  int err_cnt = 0;

  logic [15:0] m_mem [512];
  bit          m_pend_v;
  logic [15:0] m_pend;

  ads869x_reg_responder #(.DEVICE_ID(DEV_ID), .MIN_CLK_RATIO(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .spi_cs_n        (spi_cs_n),
    .spi_sclk        (spi_sclk),
    .spi_sdi         (spi_sdi),
    .spi_sdo         (spi_sdo),
    .range_sel       (range_sel),
    .int_ref_dis     (int_ref_dis),
    .dataout_pattern (dataout_pattern),
    .cfg_update      (cfg_update),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_update) cfg_cnt++;
    if (frame_err) err_cnt++;
  end

  function automatic logic [31:0] mk(input logic [6:0] c, input logic [8:0] a, input logic [15:0] d);
    return {c, a, d};
  endfunction

  function automatic bit writable(input logic [8:0] a);
    return a inside {9'h004, 9'h008, 9'h00C, 9'h010, 9'h014, 9'h024, 9'h026, 9'h028, 9'h02A};
  endfunction

  function automatic logic [15:0] rd(input logic [8:0] a);
    if (a == 9'h000) return DEV_ID;
    if (writable(a)) return m_mem[a];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 512; i++) m_mem[i] = 16'h0000;
    m_pend_v = 0;
    m_pend = 16'h0000;
  endtask

  task automatic model_frame(input logic [31:0] word, input int n, output logic [31:0] e_sdo,
                             output int e_cfg, output int e_err);
    logic [6:0] c;
    logic [8:0] a;
    logic [15:0] d, h;
    e_sdo = m_pend_v ? {m_pend, 16'h0000} : 32'h0;
    m_pend_v = 0;
    e_cfg = 0;
    e_err = (n != 32) ? 1 : 0;
    if (n != 32) return;
    c = word[31:25];
    a = word[24:16];
    d = word[15:0];
    if (writable(a)) begin
      case (c)
        C_WRITE:    begin m_mem[a] = d; e_cfg = 1; end
        C_WRITE_MS: begin m_mem[a][15:8] = d[15:8]; e_cfg = 1; end
        C_WRITE_LS: begin m_mem[a][7:0] = d[7:0]; e_cfg = 1; end
        C_SET:      begin m_mem[a] = m_mem[a] | d; e_cfg = 1; end
        C_CLEAR:    begin m_mem[a] = m_mem[a] & ~d; e_cfg = 1; end
        default:    ;
      endcase
    end
    if (c == C_RDH) begin
      m_pend = rd(a);
      m_pend_v = 1;
    end else if (c == C_READ) begin
      h = rd({a[8:1], 1'b0});
      m_pend = {a[0] ? h[15:8] : h[7:0], 8'h00};
      m_pend_v = 1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] word, input int n, output logic [31:0] got);
    got = 32'h0;
    for (int i = 0; i < n; i++) begin
      spi_sdi = (i < 32) ? word[31-i] : 1'($urandom_range(0, 1));
      #60;
      if (i < 32) got[31-i] = spi_sdo;
      spi_sclk = 1'b1;
      #60;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] word, input int n, output logic [31:0] got);
    logic [31:0] e_sdo, mask;
    int e_cfg, e_err, cfg0, err0;
    model_frame(word, n, e_sdo, e_cfg, e_err);
    cfg0 = cfg_cnt;
    err0 = err_cnt;
    spi_cs_n = 1'b0;
    #100;
    shift_bits(word, n, got);
    #60;
    spi_cs_n = 1'b1;
    #120;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
    check_output({tag, ".sdo"}, got & mask, e_sdo & mask);
    check_output({tag, ".cfg_update"}, 32'(cfg_cnt - cfg0), 32'(e_cfg));
    check_output({tag, ".frame_err"}, 32'(err_cnt - err0), 32'(e_err));
    check_output({tag, ".range_sel"}, {28'h0, range_sel}, {28'h0, m_mem[9'h014][3:0]});
    check_output({tag, ".int_ref_dis"}, {31'h0, int_ref_dis}, {31'h0, m_mem[9'h014][6]});
    check_output({tag, ".pattern"}, {29'h0, dataout_pattern}, {29'h0, m_mem[9'h010][2:0]});
    check_output({tag, ".sdo_idle"}, {31'h0, spi_sdo}, 32'h0);
  endtask

  logic [6:0] cmd_tab [10] = '{C_WRITE, C_WRITE_MS, C_WRITE_LS, C_SET, C_CLEAR,
                               C_RDH, C_READ, C_RDH, 7'h00, 7'h7F};
  logic [8:0] addr_tab [14] = '{9'h004, 9'h008, 9'h00C, 9'h010, 9'h014, 9'h024, 9'h026,
                                9'h028, 9'h02A, 9'h000, 9'h020, 9'h011, 9'h015, 9'h1FE};

  initial begin
    logic [31:0] got;
    logic [31:0] w;
    int n, cfg0, err0;
    model_reset();
    #30;
    @(negedge clk);
    check_output("reset.range_sel", {28'h0, range_sel}, 32'h0);
    check_output("reset.sdo", {31'h0, spi_sdo}, 32'h0);
    check_output("reset.pulses", {30'h0, cfg_update, frame_err}, 32'h0);
    reset_n = 1'b1;
    #100;

    run_frame("wr_range", mk(C_WRITE, 9'h014, 16'h0041), 32, got);
    check_output("wr_range.value", {28'h0, range_sel}, 32'h1);

    run_frame("wr_dataout", mk(C_WRITE, 9'h010, 16'h0005), 32, got);
    run_frame("rdh_dataout", mk(C_RDH, 9'h010, 16'h0000), 32, got);
    run_frame("nop_after_rdh", 32'h0, 32, got);
    check_output("rdh_dataout.word", got, 32'h0005_0000);

    run_frame("wr_alarm", mk(C_WRITE, 9'h024, 16'h0F00), 32, got);
    run_frame("set_alarm", mk(C_SET, 9'h024, 16'h00F0), 32, got);
    run_frame("clr_alarm", mk(C_CLEAR, 9'h024, 16'h0300), 32, got);
    run_frame("rdh_alarm", mk(C_RDH, 9'h024, 16'h0000), 32, got);
    run_frame("nop_after_alarm", 32'h0, 32, got);
    check_output("set_clear.word", got[31:16], 32'h0CF0);

    run_frame("short_frame", mk(C_WRITE, 9'h014, 16'h0002), 31, got);
    check_output("short_frame.range", {28'h0, range_sel}, 32'h1);

    run_frame("wr_devid", mk(C_WRITE, 9'h000, 16'hFFFF), 32, got);
    run_frame("rdh_devid", mk(C_RDH, 9'h000, 16'h0000), 32, got);
    run_frame("nop_after_devid", 32'h0, 32, got);
    check_output("devid.word", got[31:16], {16'h0, DEV_ID});

    run_frame("rd_byte_hi", mk(C_READ, 9'h015, 16'h0000), 32, got);
    run_frame("long_frame", mk(C_WRITE, 9'h014, 16'h0003), 33, got);

    // Reset in the middle of a write frame, then a frame already running at release.
    cfg0 = cfg_cnt;
    err0 = err_cnt;
    spi_cs_n = 1'b0;
    #100;
    shift_bits(mk(C_WRITE, 9'h014, 16'h0009), 21, got);
    reset_n = 1'b0;
    model_reset();
    #30;
    check_output("midreset.range_sel", {28'h0, range_sel}, 32'h0);
    check_output("midreset.int_ref_dis", {31'h0, int_ref_dis}, 32'h0);
    check_output("midreset.sdo", {31'h0, spi_sdo}, 32'h0);
    reset_n = 1'b1;
    #40;
    shift_bits(32'hFFFF_FFFF, 11, got);
    #60;
    spi_cs_n = 1'b1;
    #120;
    check_output("postreset.ignored_err", 32'(err_cnt - err0), 32'h0);
    check_output("postreset.ignored_cfg", 32'(cfg_cnt - cfg0), 32'h0);
    check_output("postreset.range_sel", {28'h0, range_sel}, 32'h0);
    run_frame("postreset_write", mk(C_WRITE, 9'h014, 16'h004A), 32, got);
    check_output("postreset_write.value", {28'h0, range_sel}, 32'hA);

    for (int k = 0; k < 40; k++) begin
      w = mk(cmd_tab[$urandom_range(0, 9)], addr_tab[$urandom_range(0, 13)], 16'($urandom));
      case ($urandom_range(0, 9))
        0: n = 31;
        1: n = 33;
        2: n = 16;
        default: n = 32;
      endcase
      run_frame("random", w, n, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
